// File: rtl/spike_pkg.sv
// Shared types and default widths for the spike rate decoder slice.
package spike_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } spike_dec_state_t;

    localparam int unsigned SPIKE_WINDOW_W = 8;
    localparam int unsigned SPIKE_COUNT_W  = 8;

endpackage

// File: rtl/spike_isi_tracker.sv
// Minimum inter-spike-interval tracker for one counting window.
// Only instantiated when SPIKE_DECODER_ISI_EN is defined.
module spike_isi_tracker
    import spike_pkg::*;
#(
    parameter int unsigned WIDTH = SPIKE_WINDOW_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample,
    input  logic             spike_in,
    input  logic             capture,
    output logic [WIDTH-1:0] min_isi
);

    logic             seen_q;
    logic             have_q;
    logic             have_d;
    logic             new_iv;
    logic [WIDTH-1:0] gap_q;
    logic [WIDTH-1:0] gap_inc;
    logic [WIDTH-1:0] best_q;
    logic [WIDTH-1:0] best_d;

    // gap_q counts samples since the previous spike, so gap_inc is the interval
    // that would be recorded if this sample is a spike.
    always_comb begin
        gap_inc = (&gap_q) ? gap_q : gap_q + WIDTH'(1);
        new_iv  = sample && spike_in && seen_q;
        best_d  = best_q;
        have_d  = have_q;
        if (new_iv && (!have_q || gap_inc < best_q)) begin
            best_d = gap_inc;
        end
        if (new_iv) begin
            have_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q  <= 1'b0;
            have_q  <= 1'b0;
            gap_q   <= '0;
            best_q  <= '0;
            min_isi <= '0;
        end else begin
            if (clear) begin
                seen_q <= 1'b0;
                have_q <= 1'b0;
                gap_q  <= '0;
                best_q <= '0;
            end else if (sample) begin
                if (spike_in) begin
                    seen_q <= 1'b1;
                    gap_q  <= '0;
                end else begin
                    gap_q  <= gap_inc;
                end
                best_q <= best_d;
                have_q <= have_d;
            end
            if (capture) begin
                min_isi <= have_d ? best_d : '0;
            end
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate-code receiver: counts spikes over a programmable window and reports the count.
// Optional min-ISI output enabled by defining SPIKE_DECODER_ISI_EN.
module spike_rate_decoder
    import spike_pkg::*;
#(
    parameter int unsigned WINDOW_W = SPIKE_WINDOW_W,
    parameter int unsigned COUNT_W  = SPIKE_COUNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                spike_in,
    input  logic [WINDOW_W-1:0] window_len,
    output logic [COUNT_W-1:0]  rate_out,
    output logic                rate_valid,
    output logic                overflow,
    output logic                busy
`ifdef SPIKE_DECODER_ISI_EN
    ,
    output logic [WINDOW_W-1:0] isi_out
`endif
);

    spike_dec_state_t state_q;
    spike_dec_state_t state_d;

    logic [WINDOW_W-1:0] win_q;
    logic [WINDOW_W-1:0] timer_q;
    logic [COUNT_W-1:0]  cnt_q;
    logic [COUNT_W-1:0]  cnt_d;
    logic                ovf_q;
    logic                ovf_d;
    logic                start;
    logic                last;

    // win_q - 1 wraps to all-ones for win_q == 0, giving the 2^WINDOW_W window.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    start   = 1'b1;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (timer_q == win_q - WINDOW_W'(1)) begin
                    last    = 1'b1;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (en) begin
                    start   = 1'b1;
                    state_d = COUNT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (spike_in) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q      <= '0;
            timer_q    <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            rate_out   <= '0;
            rate_valid <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy       <= (state_d != IDLE);
            rate_valid <= last;
            if (start) begin
                win_q   <= window_len;
                timer_q <= '0;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
            end else if (state_q == COUNT) begin
                timer_q <= timer_q + WINDOW_W'(1);
                cnt_q   <= cnt_d;
                ovf_q   <= ovf_d;
            end
            if (last) begin
                rate_out <= cnt_d;
                overflow <= ovf_d;
            end
        end
    end

`ifdef SPIKE_DECODER_ISI_EN
    spike_isi_tracker #(
        .WIDTH(WINDOW_W)
    ) u_isi (
        .clk      (clk),
        .rst      (rst),
        .clear    (start),
        .sample   (state_q == COUNT),
        .spike_in (spike_in),
        .capture  (last),
        .min_isi  (isi_out)
    );
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: default 8-bit counter and a 4-bit counter instance
// share stimulus; each window's expected count is queued when driven and checked on rate_valid.
module tb_spike_rate_decoder;

    logic       clk;
    logic       rst;
    logic       en;
    logic       spike_in;
    logic [7:0] window_len;

    logic [7:0] rate_out;
    logic       rate_valid;
    logic       overflow;
    logic       busy;
    logic [3:0] rate4;
    logic       valid4;
    logic       ovf4;
    logic       busy4;
`ifdef SPIKE_DECODER_ISI_EN
    logic [7:0] isi_out;
    logic [7:0] isi4;
`endif

    typedef struct packed {
        logic        ovf;
        logic [15:0] rate;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];

    int n_tests = 0;
    int n_fail  = 0;

    spike_rate_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spike_in   (spike_in),
        .window_len (window_len),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .overflow   (overflow),
        .busy       (busy)
`ifdef SPIKE_DECODER_ISI_EN
        ,
        .isi_out    (isi_out)
`endif
    );

    spike_rate_decoder #(
        .WINDOW_W (8),
        .COUNT_W  (4)
    ) dut4 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spike_in   (spike_in),
        .window_len (window_len),
        .rate_out   (rate4),
        .rate_valid (valid4),
        .overflow   (ovf4),
        .busy       (busy4)
`ifdef SPIKE_DECODER_ISI_EN
        ,
        .isi_out    (isi4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int n);
        exp_t e;
        e.rate = (n > 255) ? 16'd255 : 16'(n);
        e.ovf  = (n > 255);
        q8.push_back(e);
        e.rate = (n > 15) ? 16'd15 : 16'(n);
        e.ovf  = (n > 15);
        q4.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && rate_valid) begin
            if (q8.size() == 0) begin
                check("sb8_unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("sb8_rate", 32'(rate_out), 32'(e.rate));
                check("sb8_ovf", 32'(overflow), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid4) begin
            if (q4.size() == 0) begin
                check("sb4_unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("sb4_rate", 32'(rate4), 32'(e.rate));
                check("sb4_ovf", 32'(ovf4), 32'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        spike_in   = 1'b0;
        window_len = '0;
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_rate", 32'(rate_out), 0);
        check("rst_valid", 32'(rate_valid), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_busy4", 32'(busy4), 0);
`ifdef SPIKE_DECODER_ISI_EN
        check("rst_isi", 32'(isi_out), 0);
`endif

        // Basic count: one window of 10, spikes at samples 2, 5, 9.
        window_len = 8'd10;
        en         = 1'b1;
        push_exp(3);
        for (int c = 1; c <= 12; c++) begin
            step();
            spike_in = (c == 2 || c == 5 || c == 9);
            if (c <= 10) check("basic_busy", 32'(busy), 1);
            if (c <= 10) check("basic_novalid", 32'(rate_valid), 0);
            if (c == 11) begin
                en = 1'b0;
                check("basic_valid", 32'(rate_valid), 1);
                check("basic_rate", 32'(rate_out), 3);
                check("basic_ovf", 32'(overflow), 0);
                check("basic_busy_rep", 32'(busy), 1);
            end
            if (c == 12) begin
                check("basic_busy_off", 32'(busy), 0);
                check("basic_valid_off", 32'(rate_valid), 0);
            end
        end

        // Reset in the middle of a window.
        window_len = 8'd10;
        en         = 1'b1;
        spike_in   = 1'b1;
        for (int c = 1; c <= 5; c++) step();
        check("mid_busy_before", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_rate", 32'(rate_out), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_valid", 32'(rate_valid), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
`ifdef SPIKE_DECODER_ISI_EN
        check("mid_rst_isi", 32'(isi_out), 0);
`endif
        en       = 1'b0;
        spike_in = 1'b0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("mid_idle_busy", 32'(busy), 0);
            check("mid_idle_valid", 32'(rate_valid), 0);
        end

        // Back-to-back windows of 4 with constant spikes: period 5.
        window_len = 8'd4;
        en         = 1'b1;
        spike_in   = 1'b1;
        repeat (3) push_exp(4);
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c <= 15) check("b2b_valid", 32'(rate_valid), ((c % 5) == 0) ? 1 : 0);
            if (c <= 15) check("b2b_busy", 32'(busy), 1);
            if (c == 5 || c == 10 || c == 15) check("b2b_rate", 32'(rate_out), 4);
            if (c == 15) begin
                en       = 1'b0;
                spike_in = 1'b0;
            end
            if (c == 16) check("b2b_idle", 32'(busy), 0);
        end

        // Shortest window: length 1.
        window_len = 8'd1;
        en         = 1'b1;
        spike_in   = 1'b1;
        push_exp(1);
        step();
        step();
        en       = 1'b0;
        spike_in = 1'b0;
        check("len1_valid", 32'(rate_valid), 1);
        check("len1_rate", 32'(rate_out), 1);
        step();
        check("len1_idle", 32'(busy), 0);

        // Abort: en dropped in cycle 4 of an 8-sample window.
        window_len = 8'd8;
        en         = 1'b1;
        spike_in   = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 4) en = 1'b0;
            if (c <= 4) check("abort_busy", 32'(busy), 1);
            if (c >= 5) check("abort_idle", 32'(busy), 0);
            check("abort_novalid", 32'(rate_valid), 0);
            check("abort_rate_held", 32'(rate_out), 1);
        end
        spike_in = 1'b0;

        // Zero length (256 samples) saturating, then a quiet 256-sample window.
        window_len = 8'd0;
        en         = 1'b1;
        spike_in   = 1'b1;
        push_exp(256);
        push_exp(0);
        for (int c = 1; c <= 515; c++) begin
            step();
            if (c == 256) check("sat_novalid_last", 32'(rate_valid), 0);
            if (c == 257) begin
                spike_in = 1'b0;
                check("sat_valid", 32'(rate_valid), 1);
                check("sat_rate8", 32'(rate_out), 255);
                check("sat_ovf8", 32'(overflow), 1);
                check("sat_rate4", 32'(rate4), 15);
                check("sat_ovf4", 32'(ovf4), 1);
            end
            if (c == 514) begin
                en = 1'b0;
                check("quiet_valid", 32'(valid4), 1);
                check("quiet_rate4", 32'(rate4), 0);
                check("quiet_ovf4", 32'(ovf4), 0);
                check("quiet_ovf8", 32'(overflow), 0);
            end
            if (c == 515) check("quiet_idle", 32'(busy), 0);
        end

`ifdef SPIKE_DECODER_ISI_EN
        // ISI: window of 20 with spikes at 2, 7, 9; then a single-spike window.
        window_len = 8'd20;
        en         = 1'b1;
        spike_in   = 1'b0;
        push_exp(3);
        push_exp(1);
        for (int c = 1; c <= 43; c++) begin
            step();
            spike_in = (c == 2 || c == 7 || c == 9 || c == 26);
            if (c == 21) check("isi_min", 32'(isi_out), 2);
            if (c == 42) begin
                en = 1'b0;
                check("isi_single", 32'(isi_out), 0);
            end
        end
`endif

        step();
        step();
        check("sb8_drain", q8.size(), 0);
        check("sb4_drain", q4.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Receive end of the LIF spike interface: samples a single-bit spike train (the `spike` output of an LIF neuron, or a pad input) over a programmable window of clock cycles and reports the spike count as a rate code. It sits downstream of the neuron tile and turns spike activity back into a binary value for the output pins or for the next layer's `current` input. Windows run back-to-back while enabled.

## Interface
Parameters:
- `WINDOW_W`, default 8. Width of the window-length input and internal timer.
- `COUNT_W`, default 8. Width of the spike counter and `rate_out`.

Ports:
- `clk`, input, 1. Single clock; all logic on the rising edge.
- `rst`, input, 1. Reset, asynchronous and active-high.
- `en`, input, 1. Run enable, level-sensitive.
- `spike_in`, input, 1. Spike train, synchronous to `clk`. Each high cycle counts as one spike.
- `window_len`, input, `WINDOW_W`. Window length in samples. 0 means 2^`WINDOW_W`.
- `rate_out`, output, `COUNT_W`. Last completed window's count. Held until the next report.
- `rate_valid`, output, 1. One-cycle pulse when `rate_out` updates.
- `overflow`, output, 1. The last report saturated. Updates and holds together with `rate_out`.
- `busy`, output, 1. High in COUNT and REPORT.
- `isi_out`, output, `WINDOW_W`. Present only with `SPIKE_DECODER_ISI_EN` (see Configuration).

## Operation
- FSM states: IDLE, COUNT, REPORT.
- IDLE:
  - If `en`=1: latch `window_len` into `win_q`, clear counter and timer, go to COUNT.
  - Otherwise stay.
- COUNT:
  - Each cycle, sample `spike_in`. If high, the counter increments.
  - The counter saturates at 2^`COUNT_W`-1. An increment attempted at saturation sets the internal `ovf_q`.
  - The timer increments every cycle. On the cycle that takes sample number `win_q` (0 is treated as 2^`WINDOW_W`), transfer the final count (including that sample) to `rate_out` and `ovf_q` to `overflow`, then go to REPORT.
- REPORT:
  - `rate_valid`=1 for exactly this cycle. `spike_in` is not sampled (one dead cycle per window).
  - If `en`=1: relatch `window_len`, clear counter, timer and `ovf_q`, go to COUNT.
  - Otherwise go to IDLE.
- `en` dropped during COUNT: abort to IDLE next edge. Partial count is discarded, no `rate_valid`, and `rate_out`/`overflow` keep their previous values.
- `window_len` changes while busy are ignored until the next latch.
- `rst` at any time: immediately return to IDLE. All registers clear.

## Timing
- Reset values:
  - State IDLE.
  - `rate_out`=0, `rate_valid`=0, `overflow`=0, `busy`=0, `isi_out`=0.
  - Counter, timer, `win_q` and `ovf_q` all 0.
- Window start: cycle 0 is IDLE with `en`=1.
  - Cycles 1..L are COUNT; `spike_in` is sampled at the end of each.
  - Cycle L+1 is REPORT: `rate_valid`=1, and `rate_out`/`overflow` already hold the new values.
  - Cycle L+2 is COUNT (if `en`) or IDLE.
- Latency from the last sample to `rate_valid` is 1 cycle. The back-to-back period is L+1 cycles.
- `busy` is registered from the state: 1 in cycles 1..L+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SPIKE_DECODER_ISI_EN`.
- Defined:
  - Adds port `isi_out` and a minimum inter-spike-interval tracker.
  - The interval is the number of cycles between consecutive high samples within one window, so adjacent high samples give 1.
  - At REPORT, `isi_out` takes the window's minimum interval, or 0 if the window had fewer than 2 spikes.
  - The interval counter saturates at 2^`WINDOW_W`-1.
- Undefined:
  - No `isi_out` port and no tracker logic.
  - All other behaviour is identical.

## Structure
- Shared package `spike_pkg`:
  - FSM state enum `spike_dec_state_t` (IDLE, COUNT, REPORT).
  - Default widths `SPIKE_WINDOW_W`=8 and `SPIKE_COUNT_W`=8, used as the parameter defaults.
- One sub-module, `spike_isi_tracker`, instantiated only under `SPIKE_DECODER_ISI_EN`.
  - Inputs: `clk`, `rst`, `clear`, `sample`, `spike_in`, `capture`.
  - Output: registered minimum interval.
- The FSM, counter and timer stay in the top module.

## Test plan
- Reset mid-window: `window_len`=10, `en`=1, `spike_in`=1. Assert `rst` during cycle 5. Expect all outputs 0 immediately, IDLE afterwards, and no `rate_valid`.
- Basic count: `window_len`=10, `spike_in` high on 3 separate cycles within samples 1..10, `en` held for exactly one window. Expect `rate_valid` in cycle 11 with `rate_out`=3 and `overflow`=0, `busy` low from cycle 12.
- Back-to-back and dead cycle: `window_len`=4, `en` held, `spike_in`=1 constantly. Expect `rate_out`=4 every 5 cycles, with `rate_valid` in cycles 5, 10, 15.
- Saturation and zero length: `COUNT_W`=4, `window_len`=0 (256 samples), `spike_in`=1. Expect `rate_out`=15 and `overflow`=1. A following quiet window gives `rate_out`=0 and `overflow`=0.
- Abort: `window_len`=8, drop `en` at cycle 4. Expect no `rate_valid`, `rate_out` unchanged, IDLE next cycle.
- ISI (macro defined): `window_len`=20, spikes at samples 2, 7, 9. Expect `isi_out`=2. A single-spike window gives `isi_out`=0.
